// File: rtl/ram_boot_loader.sv
// UART-fed RAM boot loader: parses a magic/length/data/checksum frame, writes
// each assembled word to RAM and releases the CPU from reset once verified.
module ram_boot_loader #(
  parameter  int NB_COL    = 4,
  parameter  int COL_WIDTH = 8,
  parameter  int RAM_DEPTH = 1024,
  localparam int AW        = $clog2(RAM_DEPTH),
  localparam int DW        = NB_COL * COL_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              reload,
  output logic              ram_en,
  output logic [NB_COL-1:0] ram_we,
  output logic [AW-1:0]     ram_addr,
  output logic [DW-1:0]     ram_din,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  localparam int LW = (NB_COL > 1) ? $clog2(NB_COL) : 1;

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;

  state_t          state, state_nxt;
  logic [7:0]      len_lo;
  logic [15:0]     len;
  logic [LW-1:0]   lane;
  logic [AW-1:0]   widx;
  logic [DW-1:0]   word, word_asm;
  logic [7:0]      csum;

  logic            accept, last_lane, last_word;
  logic [15:0]     len_full;

  logic            ready_nxt, done_nxt, error_nxt, wr_nxt;

  // reload masks the byte stream for the cycle it is high
  assign accept    = s_valid && s_ready && !reload;
  assign last_lane = (lane == LW'(NB_COL - 1));
  assign last_word = ({{(32-AW){1'b0}}, widx} == ({16'd0, len} - 32'd1));
  assign len_full  = {s_data, len_lo};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (reload) begin
      state_nxt = IDLE;
    end else if (accept) begin
      case (state)
        IDLE: if (s_data == 8'hA5) state_nxt = LEN0;
        LEN0: state_nxt = LEN1;
        LEN1: begin
          if ({16'd0, len_full} > 32'(RAM_DEPTH)) state_nxt = ERR;
          else if (len_full == 16'd0)             state_nxt = CSUM;
          else                                    state_nxt = DATA;
        end
        DATA: if (last_lane && last_word) state_nxt = CSUM;
        CSUM: state_nxt = (s_data == csum) ? DONE : ERR;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    ready_nxt = (state_nxt == IDLE) || (state_nxt == LEN0) || (state_nxt == LEN1) ||
                (state_nxt == DATA) || (state_nxt == CSUM);
    done_nxt  = (state_nxt == DONE);
    error_nxt = (state_nxt == ERR);
    wr_nxt    = accept && (state == DATA) && last_lane;
    word_asm  = word;
    word_asm[COL_WIDTH*int'(lane) +: COL_WIDTH] = s_data;
  end

  // frame datapath: length, lane/word counters, running checksum
  always_ff @(posedge clk) begin
    if (rst || reload) begin
      len_lo <= '0;
      len    <= '0;
      lane   <= '0;
      widx   <= '0;
      word   <= '0;
      csum   <= '0;
    end else if (accept) begin
      case (state)
        LEN0: begin
          len_lo <= s_data;
          csum   <= csum ^ s_data;
        end
        LEN1: begin
          len  <= len_full;
          csum <= csum ^ s_data;
        end
        DATA: begin
          word <= word_asm;
          csum <= csum ^ s_data;
          lane <= last_lane ? '0 : lane + 1'b1;
          if (last_lane && !last_word) widx <= widx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_ready  <= 1'b0;
      cpu_rst  <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
      ram_en   <= 1'b0;
      ram_we   <= '0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      s_ready  <= ready_nxt;
      cpu_rst  <= !done_nxt;
      done     <= done_nxt;
      error    <= error_nxt;
      ram_en   <= wr_nxt;
      ram_we   <= {NB_COL{wr_nxt}};
      ram_addr <= widx;
      ram_din  <= word_asm;
    end
  end

endmodule

// File: tb/tb_ram_boot_loader.sv
// Randomized frame bench: a frame-level model queues expected RAM writes and
// a monitor checks each write against the queue as it appears.
module tb_ram_boot_loader;

  logic        clk, rst, s_valid, s_ready, reload;
  logic [7:0]  s_data;
  logic        ram_en, cpu_rst, done, error;
  logic [3:0]  ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;

  ram_boot_loader dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .reload(reload), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .cpu_rst(cpu_rst), .done(done), .error(error)
  );

  typedef struct { logic [9:0] addr; logic [31:0] data; int cyc; } wr_t;

  wr_t        sb[$];
  logic [7:0] fr[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ram_en || ram_we != 4'h0) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: addr %h data %h at cycle %0d", ram_addr, ram_din, cyc);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (ram_en !== 1'b1 || ram_we !== 4'hF || ram_addr !== e.addr ||
            ram_din !== e.data || cyc != e.cyc) begin
          n_bad++;
          $display("FAIL ram_write: got en %b we %h addr %h data %h cyc %0d expected en 1 we f addr %h data %h cyc %0d",
                   ram_en, ram_we, ram_addr, ram_din, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  // Walks the frame in fr: finds the magic, derives LEN, queues one write per
  // complete word, and checks the terminal status against the checksum rule.
  task automatic send_frame(input int maxgap, input bit chk_end);
    int p, len, n;
    logic [7:0] cs;
    bit err, exp_done;
    n = fr.size();
    p = 0;
    while (p < n && fr[p] != 8'hA5) p++;
    len = (p + 2 < n) ? int'({fr[p+2], fr[p+1]}) : 0;
    err = (len > 1024);
    cs = 8'h00;
    for (int j = p + 1; j < p + 3 + 4*len && j < n; j++) cs ^= fr[j];
    for (int j = 0; j < n; j++) begin
      repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
      s_data = fr[j];
      s_valid = 1'b1;
      if (chk_end && j == n - 1) begin
        @(negedge clk);
        chk("cpu_rst_while_loading", cpu_rst, 1);
        chk("done_while_loading", done, 0);
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      if (!err && j >= p + 3 && j < p + 3 + 4*len && (j - p - 3) % 4 == 3)
        sb.push_back('{addr: 10'((j - p - 3) / 4),
                       data: {fr[j], fr[j-1], fr[j-2], fr[j-3]}, cyc: cyc});
    end
    if (chk_end) begin
      exp_done = !err && (p + 3 + 4*len < n) && (fr[p+3+4*len] == cs);
      @(negedge clk);
      chk("done", done, exp_done);
      chk("error", error, !exp_done);
      chk("cpu_rst", cpu_rst, !exp_done);
      chk("s_ready_terminal", s_ready, 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic append_csum(input bit good);
    int p;
    logic [7:0] cs;
    p = 0;
    while (fr[p] != 8'hA5) p++;
    cs = 8'h00;
    for (int j = p + 1; j < fr.size(); j++) cs ^= fr[j];
    fr.push_back(good ? cs : cs ^ 8'h01);
  endtask

  task automatic build(input int len, input bit good, input int pre);
    logic [7:0] b;
    fr.delete();
    repeat (pre) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h00;
      fr.push_back(b);
    end
    fr.push_back(8'hA5);
    fr.push_back(len[7:0]);
    fr.push_back(len[15:8]);
    repeat (4*len) fr.push_back(8'($urandom));
    append_csum(good);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    s_valid = 1'b1;
    s_data = 8'hA5;
    @(posedge clk); #1;
    reload = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    chk("reload_cpu_rst", cpu_rst, 1);
    chk("reload_done", done, 0);
    chk("reload_error", error, 0);
    chk("reload_s_ready", s_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    reload = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_ram_en", ram_en, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_s_ready", s_ready, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    s_data = 8'h00;
    s_valid = 1'b0;
    reload = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    do_reset();

    fr = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    append_csum(1);
    send_frame(2, 1);

    do_reload();
    fr = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    append_csum(0);
    send_frame(0, 1);

    do_reload();
    fr = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
    append_csum(1);
    send_frame(1, 1);

    do_reload();
    fr = '{8'hA5, 8'h01, 8'h04};
    send_frame(0, 1);

    // abandon a 2-word frame after 6 data bytes
    do_reload();
    fr = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_frame(1, 0);
    do_reset();
    build(2, 1, 0);
    send_frame(1, 1);

    do_reload();
    fr = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    append_csum(1);
    send_frame(0, 1);

    for (int i = 0; i < 12; i++) begin
      do_reload();
      build($urandom_range(1, 8), ($urandom_range(0, 3) != 0), $urandom_range(0, 3));
      send_frame(2, 1);
    end

    do_reload();
    build(1024, 1, 0);
    send_frame(0, 1);

    repeat (3) @(posedge clk);
    chk("pending_writes", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
